// File: rtl/glitcher_pkg.sv
// rtl/glitcher_pkg.sv - shared UART line constants, tx FSM encoding and baud divisor helper
package glitcher_pkg;

  // Line levels for the 8N1 frame; shared with the receive side.
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;
  localparam int   UART_DATA_BITS   = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Integer divide: any remainder is dropped, so the line runs slightly fast.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO
//  clk, rst      : clock, synchronous active-high reset (flushes contents)
//  push, wdata   : write request and data; ignored when full
//  pop, rdata    : read request; rdata shows the head entry whenever not empty
//  full, empty   : occupancy flags
//  count         : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even if the same cycle pops.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/glitch_uart_tx.sv
// rtl/glitch_uart_tx.sv - buffered 8N1 UART transmitter for controller responses
//  clk      : system clock
//  rst      : synchronous reset, active-high; aborts any frame and drops queued bytes
//  data_i   : byte to send, sampled only on an accepting edge
//  valid_i  : byte accepted on an edge where valid_i && ready_o
//  ready_o  : buffer can accept a byte (forced low during reset)
//  tx_o     : serial line, idle high, registered
//  busy_o   : buffer non-empty or frame in progress, registered
module glitch_uart_tx
  import glitcher_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BCW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CPB - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_e      state, state_n;
  logic [BCW-1:0] baud_cnt, baud_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shift, shift_n;
  logic           tx_n;
  logic           busy_n;
  logic           bit_done;

  logic           push;
  logic           pop;
  logic [7:0]     fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  count_n;

  assign ready_o  = !fifo_full && !rst;
  assign push     = valid_i && ready_o;
  assign bit_done = (baud_cnt == BAUD_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (data_i),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx_o;
    pop     = 1'b0;

    case (state)
      TX_IDLE: begin
        tx_n = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_rdata;
          tx_n    = UART_START_LEVEL;
          baud_n  = '0;
          state_n = TX_START;
        end
      end

      TX_START: begin
        if (bit_done) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift[0];
          state_n = TX_DATA;
        end else begin
          baud_n = baud_cnt + BCW'(1);
        end
      end

      TX_DATA: begin
        if (bit_done) begin
          baud_n = '0;
          if (bit_idx == BIT_LAST) begin
            tx_n    = UART_STOP_LEVEL;
            state_n = TX_STOP;
          end else begin
            // shift[0] is the bit on the line; the next one is shift[1].
            bit_n   = bit_idx + 3'd1;
            shift_n = shift >> 1;
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud_cnt + BCW'(1);
        end
      end

      TX_STOP: begin
        if (bit_done) begin
          baud_n = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit, no idle gap.
            pop     = 1'b1;
            shift_n = fifo_rdata;
            tx_n    = UART_START_LEVEL;
            state_n = TX_START;
          end else begin
            tx_n    = UART_IDLE_LEVEL;
            state_n = TX_IDLE;
          end
        end else begin
          baud_n = baud_cnt + BCW'(1);
        end
      end

      default: begin
        tx_n    = UART_IDLE_LEVEL;
        state_n = TX_IDLE;
      end
    endcase

    // busy_o is registered, so it is computed from post-edge occupancy.
    count_n = fifo_count + CW'(push) - CW'(pop);
    busy_n  = (state_n != TX_IDLE) || (count_n != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_o     <= UART_IDLE_LEVEL;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      tx_o     <= tx_n;
      busy_o   <= busy_n;
    end
  end

endmodule

// File: tb/tb_glitch_uart_tx.sv
// tb/tb_glitch_uart_tx.sv - self-checking bench for glitch_uart_tx
module tb_glitch_uart_tx;

  localparam int CPB_A = 434;
  localparam int CPB_B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_a = 8'h00;
  logic       valid_a = 1'b0;
  logic       ready_a;
  logic       tx_a;
  logic       busy_a;
  logic [7:0] data_b = 8'h00;
  logic       valid_b = 1'b0;
  logic       ready_b;
  logic       tx_b;
  logic       busy_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];
  int         rx_starts0 = 0;
  int         rx_starts1 = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vec [5];

  glitch_uart_tx #(
    .CLK_FREQ   (50_000_000),
    .BAUD_RATE  (115200),
    .FIFO_DEPTH (4)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_a),
    .valid_i (valid_a),
    .ready_o (ready_a),
    .tx_o    (tx_a),
    .busy_o  (busy_a)
  );

  glitch_uart_tx #(
    .CLK_FREQ   (4_000_000),
    .BAUD_RATE  (1_000_000),
    .FIFO_DEPTH (4)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_b),
    .valid_i (valid_b),
    .ready_o (ready_b),
    .tx_o    (tx_b),
    .busy_o  (busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic line_of(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction

  // Mid-bit sampling receiver; frames disturbed by reset are dropped.
  task automatic rx_loop(input int w, input int cpb);
    logic [7:0] b;
    bit         ab;
    forever begin
      @(negedge clk);
      if (!rst && line_of(w) === 1'b0) begin
        if (w == 0) rx_starts0++; else rx_starts1++;
        ab = 1'b0;
        b  = 8'h00;
        repeat (cpb / 2) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        for (int i = 0; i < 9; i++) begin
          repeat (cpb) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
          end
          if (i < 8) b[i] = line_of(w);
          else if (line_of(w) !== 1'b1) ab = 1'b1;
        end
        if (!ab) begin
          if (w == 0) rxq0.push_back(b); else rxq1.push_back(b);
        end
      end
    end
  endtask

  initial rx_loop(0, CPB_A);
  initial rx_loop(1, CPB_B);

  // Called just after the start edge plus `skip` cycles; checks every cycle of the
  // frame and returns just after the edge that ends the stop bit.
  task automatic check_frame(input string name, input logic [9:0] f, input int skip);
    logic seen;
    seen = f[skip / CPB_A];
    for (int c = skip; c < 10 * CPB_A; c++) begin
      if (c % CPB_A == 0) seen = f[c / CPB_A];
      if (tx_a !== f[c / CPB_A]) seen = tx_a;
      if (c % CPB_A == CPB_A - 1)
        chk($sformatf("%s bit%0d", name, c / CPB_A), {31'd0, seen}, {31'd0, f[c / CPB_A]});
      tick();
    end
  endtask

  initial begin
    int   n_acc;
    int   acc_cyc [6];
    bit   acc;
    int   s_cyc;
    int   starts_before;
    logic tx_glitch;
    logic [7:0] exp_q[$];
    int   gap;
    int   nb;
    int   mism;
    int   budget;

    vec[0] = '{8'hA5, 10'h34A};
    vec[1] = '{8'h81, 10'h302};
    vec[2] = '{8'h00, 10'h200};
    vec[3] = '{8'hFF, 10'h3FE};
    vec[4] = '{8'h55, 10'h2AA};

    // 1. reset
    rst = 1'b1;
    tick();
    chk("rst tx", tx_a, 1);
    chk("rst busy", busy_a, 0);
    chk("rst ready", ready_a, 0);
    tick();
    tick();
    chk("rst ready held", ready_a, 0);
    rst = 1'b0;
    #1;
    chk("ready after rst", ready_a, 1);
    chk("ready_b after rst", ready_b, 1);
    tick();

    // 2. single frames from the vector table
    for (int v = 0; v < 2; v++) begin
      valid_a = 1'b1;
      data_a  = vec[v].data;
      tick();
      valid_a = 1'b0;
      data_a  = 8'hEE;
      chk($sformatf("v%0d busy after push", v), busy_a, 1);
      chk($sformatf("v%0d tx idle at push", v), tx_a, 1);
      tick();
      check_frame($sformatf("v%0d", v), vec[v].frame, 0);
      chk($sformatf("v%0d busy end", v), busy_a, 0);
      chk($sformatf("v%0d tx idle end", v), tx_a, 1);
      chk($sformatf("v%0d rx count", v), rxq0.size(), 1);
      if (rxq0.size() > 0) chk($sformatf("v%0d rx byte", v), rxq0.pop_front(), vec[v].data);
      tick();
    end

    // 3. three back-to-back frames
    valid_a = 1'b1;
    for (int v = 2; v < 5; v++) begin
      data_a = vec[v].data;
      tick();
    end
    valid_a = 1'b0;
    check_frame("b2b0", vec[2].frame, 1);
    check_frame("b2b1", vec[3].frame, 0);
    check_frame("b2b2", vec[4].frame, 0);
    chk("b2b busy end", busy_a, 0);
    chk("b2b rx count", rxq0.size(), 3);
    for (int v = 2; v < 5; v++)
      if (rxq0.size() > 0) chk($sformatf("b2b rx%0d", v - 2), rxq0.pop_front(), vec[v].data);
    rxq0.delete();
    tick();

    // 4. hold valid across a full FIFO
    n_acc   = 0;
    valid_a = 1'b1;
    data_a  = 8'h01;
    for (int c = 0; c < 12000 && n_acc < 6; c++) begin
      acc = ready_a;
      tick();
      if (acc) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 5) chk("fill ready low after 5th", ready_a, 0);
        data_a = 8'(n_acc + 1);
      end
    end
    valid_a = 1'b0;
    chk("fill accepted", n_acc, 6);
    if (n_acc == 6) begin
      chk("fill 5th edge", acc_cyc[4] - acc_cyc[0], 4);
      chk("fill 6th edge", acc_cyc[5] - acc_cyc[0], 2 + 10 * CPB_A);
    end
    budget = 0;
    while (busy_a && budget < 30000) begin
      tick();
      budget++;
    end
    chk("fill drained", busy_a, 0);
    chk("fill rx count", rxq0.size(), 6);
    for (int i = 0; i < 6; i++)
      if (rxq0.size() > 0) chk($sformatf("fill rx%0d", i), rxq0.pop_front(), i + 1);
    tick();

    // 5. reset in the middle of data bit 3
    valid_a = 1'b1;
    data_a  = 8'h3C;
    tick();
    s_cyc  = cyc + 1;
    data_a = 8'h11;
    tick();
    data_a = 8'h22;
    tick();
    valid_a = 1'b0;
    while (cyc - s_cyc < 4 * CPB_A + 100) tick();
    chk("abort bit3 level", tx_a, 1);
    chk("abort busy before", busy_a, 1);
    rst = 1'b1;
    tick();
    chk("abort tx", tx_a, 1);
    chk("abort busy", busy_a, 0);
    chk("abort ready in rst", ready_a, 0);
    rst = 1'b0;
    starts_before = rx_starts0;
    tx_glitch = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if (tx_a !== 1'b1) tx_glitch = tx_a;
      if (busy_a !== 1'b0) tx_glitch = 1'b0;
      tick();
    end
    chk("abort line idle", tx_glitch, 1);
    chk("abort no new start", rx_starts0 - starts_before, 0);
    chk("abort rx dropped", rxq0.size(), 0);
    chk("abort busy stays", busy_a, 0);

    // 6. random stream with stalls on the fast instance
    rxq1.delete();
    nb  = 0;
    gap = 0;
    for (int c = 0; c < 30000 && nb < 200; c++) begin
      if (gap > 0) begin
        valid_b = 1'b0;
        gap--;
      end else begin
        valid_b = 1'b1;
      end
      data_b = 8'($urandom);
      acc = valid_b && ready_b;
      if (acc) begin
        exp_q.push_back(data_b);
        nb++;
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      end
      tick();
    end
    valid_b = 1'b0;
    chk("rand accepted", nb, 200);
    budget = 0;
    while (busy_b && budget < 5000) begin
      tick();
      budget++;
    end
    chk("rand drained", busy_b, 0);
    repeat (10) tick();
    chk("rand rx count", rxq1.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < rxq1.size(); i++)
      if (rxq1[i] !== exp_q[i]) mism++;
    chk("rand rx order", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
